chunked_comparator: RTL and testbench

- Parametrised, multi-cycle successor to the team's 20-bit magnitude comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, most significant chunk first.
- Supports runtime signed or unsigned mode.
- Uses a start/busy/done handshake and holds the result in a register.
- Sits between datapath registers and control FSMs where a full-width single-cycle compare would limit clock rate.

---
 rtl/chunked_comparator_if.sv | 22 ++
 rtl/chunked_comparator.sv | 108 ++++++++++
 tb/tb_chunked_comparator.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/chunked_comparator_if.sv
// Handshake and operand bundle for chunked_comparator: start/operands in, busy/done/result out.
interface chunked_comparator_if #(
   parameter int WIDTH = 20
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [2:0]       out;

   modport master (
      output start, is_signed, a, b,
      input  busy, done, out
   );

   modport slave (
      input  start, is_signed, a, b,
      output busy, done, out
   );
endinterface

// File: rtl/chunked_comparator.sv
// Multi-cycle magnitude comparator, CHUNK bits per cycle, MSB chunk first, signed/unsigned.
// Define CHUNKED_COMPARATOR_EARLY_EXIT_EN to finish on the first differing chunk.
module chunked_comparator #(
   parameter int WIDTH = 20,
   parameter int CHUNK = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   chunked_comparator_if.slave  bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic {IDLE, COMPARE} state_t;
   typedef enum logic [1:0] {P_EQ, P_LT, P_GT} pend_t;

   state_t           state, state_n;
   pend_t            pend, pend_n;
   pend_t            chunk_res, final_res;
   logic [WIDTH-1:0] a_q, b_q, a_n, b_n;
   logic [IDXW-1:0]  idx, idx_n;
   logic [2:0]       out_q, out_n;
   logic             done_q, done_n;
   logic [CHUNK-1:0] ca, cb;
   logic             finish;

   function automatic logic [2:0] onehot(input pend_t p);
      case (p)
         P_LT:    onehot = 3'b100;
         P_EQ:    onehot = 3'b010;
         P_GT:    onehot = 3'b001;
         default: onehot = 3'b000;
      endcase
   endfunction

   always_comb begin
      ca = a_q[int'(idx)*CHUNK +: CHUNK];
      cb = b_q[int'(idx)*CHUNK +: CHUNK];
      if (ca < cb)      chunk_res = P_LT;
      else if (ca > cb) chunk_res = P_GT;
      else              chunk_res = P_EQ;
      // An already-decided higher chunk always wins over lower chunks.
      final_res = (pend != P_EQ) ? pend : chunk_res;
`ifdef CHUNKED_COMPARATOR_EARLY_EXIT_EN
      finish = (idx == '0) || (final_res != P_EQ);
`else
      finish = (idx == '0);
`endif
   end

   always_comb begin
      state_n = state;
      pend_n  = pend;
      a_n     = a_q;
      b_n     = b_q;
      idx_n   = idx;
      out_n   = out_q;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               // Offset-binary mapping: flipping the MSB makes an unsigned compare signed.
               a_n     = bus.a ^ (bus.is_signed ? MSB_MASK : '0);
               b_n     = bus.b ^ (bus.is_signed ? MSB_MASK : '0);
               idx_n   = IDXW'(NCHUNK - 1);
               pend_n  = P_EQ;
               state_n = COMPARE;
            end
         end
         COMPARE: begin
            pend_n = final_res;
            if (finish) begin
               out_n   = onehot(final_res);
               done_n  = 1'b1;
               state_n = IDLE;
            end else begin
               idx_n = idx - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         pend   <= P_EQ;
         a_q    <= '0;
         b_q    <= '0;
         idx    <= '0;
         out_q  <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         pend   <= pend_n;
         a_q    <= a_n;
         b_q    <= b_n;
         idx    <= idx_n;
         out_q  <= out_n;
         done_q <= done_n;
      end
   end

   assign bus.busy = (state == COMPARE);
   assign bus.done = done_q;
   assign bus.out  = out_q;
endmodule

// File: tb/tb_chunked_comparator.sv
// Directed self-checking bench for chunked_comparator (WIDTH=20, CHUNK=4).
module tb_chunked_comparator;
   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   chunked_comparator_if #(.WIDTH(20)) bus ();

   chunked_comparator #(.WIDTH(20), .CHUNK(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Counts edges until done (bounded), and how many sampled cycles had busy high.
   task automatic wait_done(output int n, output int busy_n);
      n = 0;
      busy_n = 0;
      while (!bus.done && n < 20) begin
         if (bus.busy) busy_n++;
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run_cmp(input string tag, input logic [19:0] av, input logic [19:0] bv,
                          input logic sg, input logic [2:0] exp_out,
                          input int lat_full, input int lat_early);
      int exp_lat, n, busy_n;
`ifdef CHUNKED_COMPARATOR_EARLY_EXIT_EN
      exp_lat = lat_early;
`else
      exp_lat = lat_full;
`endif
      bus.start = 1'b1;
      bus.a = av;
      bus.b = bv;
      bus.is_signed = sg;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a = ~av;
      bus.b = ~bv;
      bus.is_signed = ~sg;
      wait_done(n, busy_n);
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_busycnt"}, busy_n, exp_lat);
      check({tag, "_busy_at_done"}, int'(bus.busy), 0);
      check({tag, "_out"}, int'(bus.out), int'(exp_out));
   endtask

   initial begin
      int n, busy_n;
      tests_run = 0;
      tests_failed = 0;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.is_signed = 1'b0;
      bus.a = '0;
      bus.b = '0;
      #1;
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_out", int'(bus.out), 0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("idle_out", int'(bus.out), 0);

      run_cmp("t1_eq", 20'h12345, 20'h12345, 1'b0, 3'b010, 5, 5);
      @(posedge clk); #1;
      check("t1_done_pulse", int'(bus.done), 0);
      check("t1_hold", int'(bus.out), 3'b010);

      run_cmp("t2_lt", 20'h00001, 20'h00002, 1'b0, 3'b100, 5, 5);
      run_cmp("t3_u", 20'h80000, 20'h7FFFF, 1'b0, 3'b001, 5, 1);
      run_cmp("t3_s", 20'h80000, 20'h7FFFF, 1'b1, 3'b100, 5, 1);
      run_cmp("t4_s", 20'hFFFFF, 20'h00000, 1'b1, 3'b100, 5, 1);
      run_cmp("t4_u", 20'hFFFFF, 20'h00000, 1'b0, 3'b001, 5, 1);
      run_cmp("t4_eq", 20'hFFFFF, 20'hFFFFF, 1'b1, 3'b010, 5, 5);
      run_cmp("t4_maxmin", 20'h7FFFF, 20'h80000, 1'b1, 3'b001, 5, 1);
      repeat (3) @(posedge clk);
      #1;
      check("t4_hold", int'(bus.out), 3'b001);

      // Start held through the compare, then re-issued in the done cycle.
      bus.start = 1'b1;
      bus.a = 20'h00005;
      bus.b = 20'h00003;
      bus.is_signed = 1'b0;
      @(posedge clk); #1;
      bus.a = 20'hFFFFF;
      bus.b = 20'h00000;
      wait_done(n, busy_n);
      check("t5_first_lat", n, 5);
      check("t5_first_out", int'(bus.out), 3'b001);
      bus.a = 20'h00003;
      bus.b = 20'h00005;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      check("t5_no_gap", int'(bus.busy), 1);
      wait_done(n, busy_n);
      check("t5_second_lat", n, 5);
      check("t5_second_out", int'(bus.out), 3'b100);

      // Reset in cycle 3 of a compare, checked before any further edge.
      bus.start = 1'b1;
      bus.a = 20'h12345;
      bus.b = 20'h12344;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t6_busy_before", int'(bus.busy), 1);
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_busy", int'(bus.busy), 0);
      check("t6_rst_done", int'(bus.done), 0);
      check("t6_rst_out", int'(bus.out), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("t6_idle_busy", int'(bus.busy), 0);
      run_cmp("t6_after", 20'h00010, 20'h00001, 1'b0, 3'b001, 5, 4);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
